guineveer_mailbox_snoop: RTL and testbench
==========================================

// Module: guineveer_mailbox_snoop
// PURPOSE
//  Passive monitor on the LSU AXI write channels (AW/W) of the guineveer SoC. Pairs AW and W handshakes,
//  decodes single-byte writes to the simulation mailbox address and produces a buffered console char stream.
//  Also produces sticky pass/fail status. Feeds the bench's console printer and end-of-sim logic; never drives the bus.
// PARAMETERS
//  MBOX_ADDR       32'h80F8_0000  byte address of mailbox; lane = MBOX_ADDR[2:0]
//  FIFO_DEPTH      16             char FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  99_000_000     watchdog limit (only with GUINEVEER_MBOX_TIMEOUT_EN)
// PORTS
//  clk_i         in   1   core clock
//  rst_ni        in   1   async active-low reset
//  aw_valid_i    in   1   snooped AW valid
//  aw_ready_i    in   1   snooped AW ready
//  aw_addr_i     in   32  snooped AW address
//  aw_len_i      in   8   snooped AW burst length (beats-1)
//  w_valid_i     in   1   snooped W valid
//  w_ready_i     in   1   snooped W ready
//  w_data_i      in   64  snooped W data
//  w_strb_i      in   8   snooped W strobes
//  w_last_i      in   1   snooped W last
//  char_valid_o  out  1   console char available
//  char_ready_i  in   1   consumer accepts char
//  char_data_o   out  8   console char (FIFO head)
//  pass_o        out  1   sticky: 0xFF written
//  fail_o        out  1   sticky: 0x01 written
//  timeout_o     out  1   sticky: watchdog expired
//  overflow_o    out  1   sticky: char dropped, FIFO full
//  proto_err_o   out  1   sticky: pairing violation
// BEHAVIOUR
//  - Reset (async, rst_ni=0): all outputs 0, FIFO empty, pending slots empty, FSM=RUN, watchdog=0.
//  - Handshake: AW hs = aw_valid_i&aw_ready_i; W hs = w_valid_i&w_ready_i. Valid without ready is ignored.
//  - AW slot (1 entry): on AW hs, stores match=(aw_addr_i==MBOX_ADDR)&&(aw_len_i==0). Freed when the W beat with w_last_i retires.
//    The slot is freed in the same cycle if that beat arrives together with the AW hs.
//  - AW hs with aw_addr_i==MBOX_ADDR and aw_len_i!=0 -> proto_err_o; the burst is tracked but not decoded.
//  - W beat with AW slot full (or same-cycle AW hs): beat paired and consumed.
//  - W beat with no AW available: stored in 1-entry W slot. It pairs on the next AW hs, in the AW-hs cycle.
//  - W hs while W slot full and no AW -> beat dropped, proto_err_o=1.
//  - AW hs while AW slot full and not retiring this cycle -> AW dropped, proto_err_o=1.
//  - Decode, on a paired beat with match=1, in FSM=RUN, and w_strb_i[lane]=1: byte b = data[8*lane+:8].
//      b==8'hFF           -> FSM PASS, pass_o=1 next cycle
//      b==8'h01           -> FSM FAIL, fail_o=1 next cycle
//      8'h06<=b<=8'h7E    -> push b to FIFO
//      other / strb=0     -> ignored
//  - FSM: RUN->PASS | FAIL | TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset; decode is suppressed in them.
//  - FIFO: push latency 1 (char_valid_o rises the cycle after the pairing hs). Pop on char_valid_o&char_ready_i.
//    Simultaneous push+pop when full: legal, no drop.
//    Push when full with no pop: char dropped, overflow_o=1. Pointers wrap modulo FIFO_DEPTH.
//  - Chars already buffered still drain after pass/fail/timeout.
//  - Sticky flags clear only on reset. Reset mid-burst discards all slots and FIFO contents.
// CONFIGURATION
//  GUINEVEER_MBOX_TIMEOUT_EN defined:
//    - 32-bit watchdog increments each cycle in RUN and saturates.
//    - When watchdog==TIMEOUT_CYCLES-1 in RUN: next cycle FSM=TIMEOUT, timeout_o=1.
//  GUINEVEER_MBOX_TIMEOUT_EN undefined: no counter, timeout_o tied 0, FSM never enters TIMEOUT.
// TESTING
//  1 AW(0x80F80000,len0)+W(data=0x41,strb=0x01) same cycle -> next cycle char_valid_o=1, char_data_o=0x41.
//  2 W(0x48) 3 cycles before AW(mbox) -> char 0x48 appears 1 cycle after AW hs. Then AW(0x80000000)+W(0x49) -> no char.
//  3 Write 0x05, 0x7F, 0x42 with strb=0x00 -> FIFO stays empty. Write 0xFF -> pass_o=1.
//    Later write 0x01 -> fail_o stays 0.
//  4 char_ready_i=0, write 17 chars 0x61..0x71 (depth 16) -> overflow_o=1.
//    Then ready=1 -> 0x61..0x70 drain in order, 0x71 lost.
//  5 Two W hs with no AW -> proto_err_o=1. AW(mbox,len=3) -> proto_err_o=1, no chars.
//  6 With GUINEVEER_MBOX_TIMEOUT_EN, TIMEOUT_CYCLES=100, no writes -> timeout_o=1 at cycle 100.
//    Later 0xFF ignored. Without the macro: timeout_o=0.

Source files
------------

// File: rtl/guineveer_mailbox_snoop.sv
// Passive AW/W snoop: pairs write handshakes, decodes mailbox byte writes into a console char FIFO and sticky status.
// Optional watchdog enabled by defining GUINEVEER_MBOX_TIMEOUT_EN.
module guineveer_mailbox_snoop #(
    parameter logic [31:0] MBOX_ADDR      = 32'h80F8_0000,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 99_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        aw_valid_i,
    input  logic        aw_ready_i,
    input  logic [31:0] aw_addr_i,
    input  logic [7:0]  aw_len_i,
    input  logic        w_valid_i,
    input  logic        w_ready_i,
    input  logic [63:0] w_data_i,
    input  logic [7:0]  w_strb_i,
    input  logic        w_last_i,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [7:0]  char_data_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic        overflow_o,
    output logic        proto_err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LANE  = int'(MBOX_ADDR[2:0]);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    state_e state_q, state_d;

    logic aw_full_q, aw_full_d;
    logic aw_match_q, aw_match_d;
    logic w_full_q, w_full_d;
    logic [7:0] w_byte_q, w_byte_d;
    logic w_bstrb_q, w_bstrb_d;
    logic w_last_q, w_last_d;

    logic [7:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic char_valid_q, pass_q, fail_q, timeout_q, overflow_q, proto_err_q;

    logic aw_hs_c, w_hs_c, aw_match_new_c;
    logic pair_c, pair_match_c, pair_strb_c, perr_c;
    logic [7:0] pair_byte_c;
    logic [7:0] in_byte_c;
    logic in_strb_c;
    logic dec_en_c, push_c, pop_c, full_c, do_push_c, drop_c;
    logic unused_c;

    assign aw_hs_c        = aw_valid_i & aw_ready_i;
    assign w_hs_c         = w_valid_i & w_ready_i;
    assign aw_match_new_c = (aw_addr_i == MBOX_ADDR) && (aw_len_i == 8'd0);
    assign in_byte_c      = w_data_i[8*LANE +: 8];
    assign in_strb_c      = w_strb_i[LANE];

    // AW/W pairing; the two slots are never both occupied.
    always_comb begin
        aw_full_d    = aw_full_q;
        aw_match_d   = aw_match_q;
        w_full_d     = w_full_q;
        w_byte_d     = w_byte_q;
        w_bstrb_d    = w_bstrb_q;
        w_last_d     = w_last_q;
        pair_c       = 1'b0;
        pair_match_c = 1'b0;
        pair_byte_c  = in_byte_c;
        pair_strb_c  = in_strb_c;
        perr_c       = 1'b0;

        if (aw_full_q) begin
            if (w_hs_c) begin
                pair_c       = 1'b1;
                pair_match_c = aw_match_q;
                if (w_last_i) aw_full_d = 1'b0;
            end
            if (aw_hs_c) begin
                if (w_hs_c && w_last_i) begin
                    aw_full_d  = 1'b1;
                    aw_match_d = aw_match_new_c;
                end else begin
                    perr_c = 1'b1;
                end
            end
        end else if (w_full_q) begin
            if (aw_hs_c) begin
                pair_c       = 1'b1;
                pair_match_c = aw_match_new_c;
                pair_byte_c  = w_byte_q;
                pair_strb_c  = w_bstrb_q;
                w_full_d     = 1'b0;
                if (!w_last_q) begin
                    // A second beat in this cycle rides the same burst undecoded.
                    aw_full_d  = !(w_hs_c && w_last_i);
                    aw_match_d = aw_match_new_c;
                end else if (w_hs_c) begin
                    w_full_d  = 1'b1;
                    w_byte_d  = in_byte_c;
                    w_bstrb_d = in_strb_c;
                    w_last_d  = w_last_i;
                end
            end else if (w_hs_c) begin
                perr_c = 1'b1;
            end
        end else begin
            if (aw_hs_c && w_hs_c) begin
                pair_c       = 1'b1;
                pair_match_c = aw_match_new_c;
                if (!w_last_i) begin
                    aw_full_d  = 1'b1;
                    aw_match_d = aw_match_new_c;
                end
            end else if (aw_hs_c) begin
                aw_full_d  = 1'b1;
                aw_match_d = aw_match_new_c;
            end else if (w_hs_c) begin
                w_full_d  = 1'b1;
                w_byte_d  = in_byte_c;
                w_bstrb_d = in_strb_c;
                w_last_d  = w_last_i;
            end
        end

        if (aw_hs_c && (aw_addr_i == MBOX_ADDR) && (aw_len_i != 8'd0)) perr_c = 1'b1;
    end

    assign dec_en_c = pair_c && pair_match_c && pair_strb_c && (state_q == ST_RUN);
    assign push_c   = dec_en_c && (pair_byte_c >= 8'h06) && (pair_byte_c <= 8'h7E);

    assign pop_c     = char_valid_q & char_ready_i;
    assign full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign do_push_c = push_c && (!full_c || pop_c);
    assign drop_c    = push_c && full_c && !pop_c;
    assign cnt_d     = cnt_q + CNT_W'(do_push_c) - CNT_W'(pop_c);

`ifdef GUINEVEER_MBOX_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if ((state_q == ST_RUN) && (wdog_q != 32'hFFFF_FFFF)) wdog_d = wdog_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wdog_q <= 32'd0;
        else         wdog_q <= wdog_d;
    end

    assign unused_c = &{1'b0, w_data_i, w_strb_i};
`else
    logic [31:0] unused_timeout_c;
    assign unused_timeout_c = 32'(TIMEOUT_CYCLES);
    assign unused_c = &{1'b0, w_data_i, w_strb_i, unused_timeout_c};
`endif

    // Terminal FSM; a decoded pass/fail byte takes precedence over a same-cycle watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (dec_en_c && (pair_byte_c == 8'hFF)) begin
                state_d = ST_PASS;
            end else if (dec_en_c && (pair_byte_c == 8'h01)) begin
                state_d = ST_FAIL;
            end
`ifdef GUINEVEER_MBOX_TIMEOUT_EN
            else if (wdog_q == WDOG_LAST) begin
                state_d = ST_TIMEOUT;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_RUN;
            aw_full_q    <= 1'b0;
            aw_match_q   <= 1'b0;
            w_full_q     <= 1'b0;
            w_byte_q     <= 8'h00;
            w_bstrb_q    <= 1'b0;
            w_last_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            char_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            aw_full_q    <= aw_full_d;
            aw_match_q   <= aw_match_d;
            w_full_q     <= w_full_d;
            w_byte_q     <= w_byte_d;
            w_bstrb_q    <= w_bstrb_d;
            w_last_q     <= w_last_d;
            cnt_q        <= cnt_d;
            char_valid_q <= (cnt_d != '0);
            pass_q       <= pass_q | (state_d == ST_PASS);
            fail_q       <= fail_q | (state_d == ST_FAIL);
            timeout_q    <= timeout_q | (state_d == ST_TIMEOUT);
            overflow_q   <= overflow_q | drop_c;
            proto_err_q  <= proto_err_q | perr_c;
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= pair_byte_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign char_valid_o = char_valid_q;
    assign char_data_o  = mem_q[rd_ptr_q];
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign timeout_o    = timeout_q;
    assign overflow_o   = overflow_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_guineveer_mailbox_snoop.sv
// Directed bench for guineveer_mailbox_snoop: pairing, decode, FIFO, sticky flags, optional watchdog.
module tb_guineveer_mailbox_snoop;

    localparam logic [31:0] MBOX = 32'h80F8_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, char_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len, w_strb;
    logic [63:0] w_data;
    logic        char_valid, pass, fail, timeout, overflow, proto_err;
    logic [7:0]  char_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guineveer_mailbox_snoop #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .char_valid_o(char_valid), .char_ready_i(char_ready), .char_data_o(char_data),
        .pass_o(pass), .fail_o(fail), .timeout_o(timeout), .overflow_o(overflow), .proto_err_o(proto_err)
    );

    task automatic clear_bus();
        aw_valid = 1'b0; aw_ready = 1'b0; aw_addr = 32'h0; aw_len = 8'h0;
        w_valid = 1'b0; w_ready = 1'b0; w_data = 64'h0; w_strb = 8'h0; w_last = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clear_bus(); char_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // AW and W handshake in the same cycle; returns at the following negedge.
    task automatic write_mbox(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] b, input logic [7:0] strb);
        @(negedge clk);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = addr; aw_len = len;
        w_valid = 1'b1; w_ready = 1'b1; w_data = {56'h0, b}; w_strb = strb; w_last = 1'b1;
        @(negedge clk);
        clear_bus();
    endtask

    task automatic w_only(input logic [7:0] b, input logic last);
        @(negedge clk);
        w_valid = 1'b1; w_ready = 1'b1; w_data = {56'h0, b}; w_strb = 8'h01; w_last = last;
        @(negedge clk);
        clear_bus();
    endtask

    task automatic aw_only(input logic [31:0] addr, input logic [7:0] len);
        @(negedge clk);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = addr; aw_len = len;
        @(negedge clk);
        clear_bus();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; clear_bus(); char_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({char_valid, char_data, pass, fail, timeout, overflow, proto_err} !== 14'h0) begin
            $display("FAIL reset_outputs: got %h exp 0", {char_valid, char_data, pass, fail, timeout, overflow, proto_err});
            errors++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_same_cycle();
        write_mbox(MBOX, 8'd0, 8'h41, 8'h01);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h41) begin
            $display("FAIL same_cycle_char: got v=%b d=%h exp v=1 d=41", char_valid, char_data);
            errors++;
        end
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
        checks++;
        if (char_valid !== 1'b0) begin
            $display("FAIL same_cycle_pop: got v=%b exp 0", char_valid);
            errors++;
        end
    endtask

    task automatic test_w_before_aw();
        w_only(8'h48, 1'b1);
        idle(2);
        checks++;
        if (char_valid !== 1'b0 || proto_err !== 1'b0) begin
            $display("FAIL w_early_wait: got v=%b perr=%b exp 0 0", char_valid, proto_err);
            errors++;
        end
        aw_only(MBOX, 8'd0);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h48) begin
            $display("FAIL w_early_char: got v=%b d=%h exp v=1 d=48", char_valid, char_data);
            errors++;
        end
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
        write_mbox(32'h8000_0000, 8'd0, 8'h49, 8'h01);
        checks++;
        if (char_valid !== 1'b0 || proto_err !== 1'b0) begin
            $display("FAIL other_addr: got v=%b perr=%b exp 0 0", char_valid, proto_err);
            errors++;
        end
    endtask

    task automatic test_decode_pass();
        write_mbox(MBOX, 8'd0, 8'h05, 8'h01);
        write_mbox(MBOX, 8'd0, 8'h7F, 8'h01);
        write_mbox(MBOX, 8'd0, 8'h42, 8'h00);
        checks++;
        if (char_valid !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
            $display("FAIL ignored_bytes: got v=%b p=%b f=%b exp 0 0 0", char_valid, pass, fail);
            errors++;
        end
        write_mbox(MBOX, 8'd0, 8'hFF, 8'h01);
        checks++;
        if (pass !== 1'b1 || char_valid !== 1'b0) begin
            $display("FAIL pass_set: got p=%b v=%b exp p=1 v=0", pass, char_valid);
            errors++;
        end
        write_mbox(MBOX, 8'd0, 8'h01, 8'h01);
        write_mbox(MBOX, 8'd0, 8'h41, 8'h01);
        checks++;
        if (fail !== 1'b0 || pass !== 1'b1 || char_valid !== 1'b0) begin
            $display("FAIL after_pass: got f=%b p=%b v=%b exp 0 1 0", fail, pass, char_valid);
            errors++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) write_mbox(MBOX, 8'd0, 8'(8'h61 + i), 8'h01);
        checks++;
        if (overflow !== 1'b0 || char_valid !== 1'b1) begin
            $display("FAIL fill16: got ovf=%b v=%b exp 0 1", overflow, char_valid);
            errors++;
        end
        write_mbox(MBOX, 8'd0, 8'h71, 8'h01);
        checks++;
        if (overflow !== 1'b1) begin
            $display("FAIL overflow_set: got %b exp 1", overflow);
            errors++;
        end
        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (char_valid !== 1'b1 || char_data !== 8'(8'h61 + i)) begin
                $display("FAIL drain_%0d: got v=%b d=%h exp v=1 d=%h", i, char_valid, char_data, 8'(8'h61 + i));
                errors++;
            end
            @(negedge clk);
        end
        char_ready = 1'b0;
        checks++;
        if (char_valid !== 1'b0) begin
            $display("FAIL drain_empty: got v=%b exp 0", char_valid);
            errors++;
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) write_mbox(MBOX, 8'd0, 8'(8'h30 + i), 8'h01);
        @(negedge clk);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = MBOX; aw_len = 8'd0;
        w_valid = 1'b1; w_ready = 1'b1; w_data = 64'h40; w_strb = 8'h01; w_last = 1'b1;
        char_ready = 1'b1;
        @(negedge clk);
        clear_bus();
        char_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || char_valid !== 1'b1 || char_data !== 8'h31) begin
            $display("FAIL full_push_pop: got ovf=%b v=%b d=%h exp 0 1 31", overflow, char_valid, char_data);
            errors++;
        end
        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (char_data !== 8'(8'h31 + i)) begin
                $display("FAIL pp_drain_%0d: got d=%h exp d=%h", i, char_data, 8'(8'h31 + i));
                errors++;
            end
            @(negedge clk);
        end
        char_ready = 1'b0;
        checks++;
        if (char_valid !== 1'b0) begin
            $display("FAIL pp_empty: got v=%b exp 0", char_valid);
            errors++;
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        w_only(8'h41, 1'b1);
        checks++;
        if (proto_err !== 1'b0) begin
            $display("FAIL one_w: got perr=%b exp 0", proto_err);
            errors++;
        end
        w_only(8'h42, 1'b1);
        checks++;
        if (proto_err !== 1'b1 || char_valid !== 1'b0) begin
            $display("FAIL two_w: got perr=%b v=%b exp 1 0", proto_err, char_valid);
            errors++;
        end
        do_reset();
        aw_only(MBOX, 8'd3);
        checks++;
        if (proto_err !== 1'b1) begin
            $display("FAIL mbox_burst: got perr=%b exp 1", proto_err);
            errors++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_ready = 1'b1; w_data = 64'h41; w_strb = 8'h01; w_last = (i == 3);
            @(negedge clk);
        end
        clear_bus();
        checks++;
        if (char_valid !== 1'b0) begin
            $display("FAIL burst_no_char: got v=%b exp 0", char_valid);
            errors++;
        end
        write_mbox(MBOX, 8'd0, 8'h43, 8'h01);
        checks++;
        if (char_valid !== 1'b1 || char_data !== 8'h43) begin
            $display("FAIL post_burst_char: got v=%b d=%h exp 1 43", char_valid, char_data);
            errors++;
        end
        do_reset();
        aw_only(32'h8000_0000, 8'd0);
        checks++;
        if (proto_err !== 1'b0) begin
            $display("FAIL one_aw: got perr=%b exp 0", proto_err);
            errors++;
        end
        aw_only(32'h8000_0000, 8'd0);
        checks++;
        if (proto_err !== 1'b1) begin
            $display("FAIL two_aw: got perr=%b exp 1", proto_err);
            errors++;
        end
    endtask

    task automatic test_timeout();
        logic exp_to;
`ifdef GUINEVEER_MBOX_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        do_reset();
        idle(99);
        checks++;
        if (timeout !== 1'b0) begin
            $display("FAIL timeout_early: got %b exp 0", timeout);
            errors++;
        end
        idle(1);
        checks++;
        if (timeout !== exp_to) begin
            $display("FAIL timeout_at_100: got %b exp %b", timeout, exp_to);
            errors++;
        end
        write_mbox(MBOX, 8'd0, 8'hFF, 8'h01);
        checks++;
        if (pass !== ~exp_to) begin
            $display("FAIL pass_after_timeout: got %b exp %b", pass, ~exp_to);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_decode_pass();
        test_overflow();
        test_full_push_pop();
        test_proto_err();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
